instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Supports a single-cycle redirect (jump/branch) that flushes all prefetched and in-flight work.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request; held high until imem_ack.
- imem_addr  out  32  read address; stable while imem_req is high.
- imem_ack  in  1  read data valid this cycle; ignored unless imem_req is high.
- imem_rdata  in  32  instruction word; sampled when imem_ack is high.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decoder accepts the head this cycle.
- instruction  out  32  head instruction word (feeds the decoder's instruction input).
- instr_pc  out  32  PC of the head word.
- redirect  in  1  discard all prefetch work and restart at redirect_pc.
- redirect_pc  in  32  new fetch PC; sampled when redirect is high.
- fetch_cnt  out  32  performance counter (see Optional Feature).
- stall_cnt  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instruction=0, instr_pc=0.
  - FIFO empty, fetch_pc=RESET_PC, state=IDLE, counters=0.
- Occupancy: occ = FIFO count + in-flight (0 or 1). At most one outstanding request.
- State IDLE:
  - If occ < DEPTH and no redirect, go to REQ next cycle. imem_req=1 and imem_addr=fetch_pc are registered.
  - If redirect: fetch_pc <= redirect_pc, stay IDLE for one cycle.
- State REQ (imem_req=1):
  - On imem_ack with no redirect, push {fetch_pc, imem_rdata} and set fetch_pc += PC_STEP (mod 2^32, wraps silently).
  - After the ack, if occupancy after this cycle's push/pop is still < DEPTH, stay in REQ with the new address the next cycle (back-to-back fetch). Otherwise go to IDLE and drop imem_req.
  - Redirect without ack: go to FLUSH. Keep imem_req high until the ack, because a request may not be withdrawn. fetch_pc <= redirect_pc.
  - Redirect with ack in the same cycle: discard the returned word, fetch_pc <= redirect_pc, go to IDLE.
- State FLUSH:
  - Keep the request asserted with the old address. On imem_ack, discard the data and go to IDLE.
  - A further redirect in FLUSH overwrites fetch_pc; stay in FLUSH.
- Redirect flush:
  - FIFO cleared in the same cycle; instr_valid=0 the next cycle.
  - A pop in the redirect cycle is still honoured (decoder consumed it).
- FIFO:
  - Registered outputs; instruction/instr_pc reflect the head.
  - Latency: ack at cycle N gives instr_valid at N+1 when the FIFO was empty.
  - Simultaneous push and pop when full is legal only if a pop occurs. The fetch logic never issues when occ == DEPTH, so overflow is impossible.
  - Pointers wrap modulo DEPTH.
- Decoder handshake: the head is popped when instr_valid && instr_ready. Outputs hold steady while valid and not ready.
- Reset mid-request: the request is abandoned and a late imem_ack is ignored (imem_req=0). The memory model must tolerate an abandoned request.

Optional Feature:
- IFU_PERF_CNT_EN defined:
  - fetch_cnt increments on each word pushed into the FIFO.
  - stall_cnt increments each cycle instr_valid && !instr_ready.
  - Both are 32-bit, wrap, cleared by rst.
- Not defined: both ports tied to 0, no counter flops.

Test Plan:
- Reset, imem_ack=1 every cycle when requested, instr_ready=1, memory returns word = addr:
  - Decoder sees pc 0,4,8,C with instruction==pc.
  - First instr_valid 2 cycles after rst deassert, then one word per cycle.
- instr_ready=0 with zero-latency memory:
  - Exactly 4 requests issued, then imem_req=0.
  - Raise ready: 4 words drain in order and fetch resumes at 0x10.
- Memory latency 3 cycles, redirect to 0x100 while a request to 0x8 is outstanding:
  - State goes to FLUSH and the 0x8 data is discarded.
  - Next imem_addr=0x100; decoder sees no pc 0x8.
- Redirect to 0x40 coincident with imem_ack:
  - Ack data is not pushed, FIFO is empty next cycle, next fetch is 0x40.
- Redirect to 0xFFFF_FFFC:
  - Fetches 0xFFFF_FFFC then 0x0000_0000 (wrap).
- With IFU_PERF_CNT_EN: 10 accepted fetches and 3 ready-low cycles while valid give fetch_cnt=10 and stall_cnt=3. Without the macro, both read 0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and the decoder.
// master = fetch unit side, slave = memory/decoder/control side.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    modport master (
        output imem_req, imem_addr, instr_valid, instruction, instr_pc,
               fetch_cnt, stall_cnt,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instruction, instr_pc,
               fetch_cnt, stall_cnt,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC + single-outstanding imem request, prefetch FIFO to decode, redirect flush.
// Optional performance counters enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter int          DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master ifu
);

    localparam int            AW   = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_fetch_pc_next;
    logic          r_req;
    logic          w_req_next;
    logic [31:0]   r_addr;
    logic [31:0]   w_addr_next;
    logic [31:0]   w_pc_inc;

    logic [31:0]   r_mem_word [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] w_rd_ptr_next;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_after_pop;
    logic [AW:0]   w_count_next;
    logic          r_instr_valid;
    logic [31:0]   r_instruction;
    logic [31:0]   r_instr_pc;

    logic          w_pop;
    logic          w_ack;
    logic          w_push;

    assign w_pop    = r_instr_valid & ifu.instr_ready;
    assign w_ack    = r_req & ifu.imem_ack;
    // Returned data only enters the FIFO for a live (non-flushed) request.
    assign w_push   = (r_state == REQ) & w_ack & ~ifu.redirect;
    assign w_pc_inc = r_fetch_pc + PC_STEP;

    always_comb begin
        w_count_after_pop = w_pop  ? (r_count - 1'b1) : r_count;
        w_count_next      = w_push ? (w_count_after_pop + 1'b1) : w_count_after_pop;
        w_rd_ptr_next     = w_pop  ? (r_rd_ptr + 1'b1) : r_rd_ptr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_req      <= w_req_next;
            r_addr     <= w_addr_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_req_next      = r_req;
        w_addr_next     = r_addr;
        case (r_state)
            IDLE: begin
                if (ifu.redirect) begin
                    w_fetch_pc_next = ifu.redirect_pc;
                end else if (r_count < FULL) begin
                    w_state_next = REQ;
                    w_req_next   = 1'b1;
                    w_addr_next  = r_fetch_pc;
                end
            end
            REQ: begin
                if (ifu.redirect) begin
                    w_fetch_pc_next = ifu.redirect_pc;
                    if (w_ack) begin
                        w_state_next = IDLE;
                        w_req_next   = 1'b0;
                    end else begin
                        // A request cannot be withdrawn; wait out its ack.
                        w_state_next = FLUSH;
                    end
                end else if (w_ack) begin
                    w_fetch_pc_next = w_pc_inc;
                    if (w_count_next < FULL) begin
                        w_addr_next = w_pc_inc;
                    end else begin
                        w_state_next = IDLE;
                        w_req_next   = 1'b0;
                    end
                end
            end
            FLUSH: begin
                if (ifu.redirect) begin
                    w_fetch_pc_next = ifu.redirect_pc;
                end
                if (w_ack) begin
                    w_state_next = IDLE;
                    w_req_next   = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_word[r_wr_ptr] <= ifu.imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

    // Head registers are loaded from the next read pointer, or straight from the
    // incoming word when the FIFO would otherwise be empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_instr_valid <= 1'b0;
            r_instruction <= '0;
            r_instr_pc    <= '0;
        end else if (ifu.redirect) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr      <= w_rd_ptr_next;
            r_count       <= w_count_next;
            r_instr_valid <= (w_count_next != '0);
            if (w_count_next != '0) begin
                if (w_count_after_pop == '0) begin
                    r_instruction <= ifu.imem_rdata;
                    r_instr_pc    <= r_fetch_pc;
                end else begin
                    r_instruction <= r_mem_word[w_rd_ptr_next];
                    r_instr_pc    <= r_mem_pc[w_rd_ptr_next];
                end
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_push) begin
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            end
            if (r_instr_valid && !ifu.instr_ready) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign ifu.fetch_cnt = r_fetch_cnt;
    assign ifu.stall_cnt = r_stall_cnt;
`else
    assign ifu.fetch_cnt = '0;
    assign ifu.stall_cnt = '0;
`endif

    assign ifu.imem_req    = r_req;
    assign ifu.imem_addr   = r_addr;
    assign ifu.instr_valid = r_instr_valid;
    assign ifu.instruction = r_instruction;
    assign ifu.instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model returns word == address with configurable latency.
// Expected counter values follow IFU_PERF_CNT_EN.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        tb_ready;
    logic        tb_redirect;
    logic [31:0] tb_redirect_pc;
    logic [31:0] mem_lat;
    logic [31:0] ack_limit;
    logic [31:0] wait_cnt;
    logic [31:0] ack_total;

    int n_checks;
    int n_errors;

    logic [31:0] pop_pc[$];
    logic [31:0] pop_ins[$];
    logic [31:0] acc_addr[$];

    instr_fetch_unit_if bus ();

    instr_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .ifu (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.instr_ready = tb_ready;
    assign bus.redirect    = tb_redirect;
    assign bus.redirect_pc = tb_redirect_pc;
    assign bus.imem_rdata  = bus.imem_addr;
    assign bus.imem_ack    = bus.imem_req && (wait_cnt >= mem_lat) && (ack_total < ack_limit);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            ack_total <= '0;
        end else begin
            if (!bus.imem_req || bus.imem_ack) wait_cnt <= '0;
            else                               wait_cnt <= wait_cnt + 1;
            if (bus.imem_req && bus.imem_ack)  ack_total <= ack_total + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.instr_valid && bus.instr_ready) begin
                pop_pc.push_back(bus.instr_pc);
                pop_ins.push_back(bus.instruction);
                $display("  decode pc=%h instr=%h", bus.instr_pc, bus.instruction);
            end
            if (bus.imem_req && bus.imem_ack) begin
                acc_addr.push_back(bus.imem_addr);
                $display("  fetch  addr=%h", bus.imem_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset(input logic [31:0] lat, input logic [31:0] limit, input logic rdy);
        rst            = 1'b1;
        mem_lat        = lat;
        ack_limit      = limit;
        tb_ready       = rdy;
        tb_redirect    = 1'b0;
        tb_redirect_pc = '0;
        repeat (2) tick();
        pop_pc.delete();
        pop_ins.delete();
        acc_addr.delete();
        rst = 1'b0;
    endtask

    function automatic int count_pc(input logic [31:0] pc);
        int n = 0;
        foreach (pop_pc[i]) if (pop_pc[i] == pc) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;
        n_checks = 0;
        n_errors = 0;

        // Reset state, then streaming with zero-latency memory.
        rst = 1'b1; tb_ready = 1'b1; tb_redirect = 1'b0; tb_redirect_pc = '0;
        mem_lat = 0; ack_limit = 32'hFFFF_FFFF;
        tick();
        chk("rst_req",   bus.imem_req,    32'h0);
        chk("rst_addr",  bus.imem_addr,   32'h0);
        chk("rst_valid", bus.instr_valid, 32'h0);
        chk("rst_instr", bus.instruction, 32'h0);
        chk("rst_pc",    bus.instr_pc,    32'h0);
        chk("rst_fcnt",  bus.fetch_cnt,   32'h0);
        chk("rst_scnt",  bus.stall_cnt,   32'h0);
        apply_reset(0, 32'hFFFF_FFFF, 1'b1);
        tick();
        chk("t1_valid_c1", bus.instr_valid, 32'h0);
        chk("t1_req_c1",   bus.imem_req,    32'h1);
        chk("t1_addr_c1",  bus.imem_addr,   32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t1_valid", bus.instr_valid, 32'h1);
            chk("t1_pc",    bus.instr_pc,    32'(4 * k));
            chk("t1_instr", bus.instruction, 32'(4 * k));
        end

        // Decoder stalled: exactly DEPTH requests, then drain in order.
        apply_reset(0, 32'hFFFF_FFFF, 1'b0);
        repeat (10) tick();
        chk("t2_nreq",  32'(acc_addr.size()), 32'd4);
        chk("t2_req",   bus.imem_req,    32'h0);
        chk("t2_valid", bus.instr_valid, 32'h1);
        chk("t2_head",  bus.instr_pc,    32'h0);
        pop_pc.delete();
        pop_ins.delete();
        tb_ready = 1'b1;
        repeat (8) tick();
        chk("t2_npop", 32'(pop_pc.size() >= 5), 32'h1);
        if (pop_pc.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("t2_drain_pc", pop_pc[k], 32'(4 * k));
        end
        chk("t2_nacc", 32'(acc_addr.size() >= 5), 32'h1);
        if (acc_addr.size() >= 5) chk("t2_resume", acc_addr[4], 32'h10);

        // Redirect while a slow request to 0x8 is outstanding.
        apply_reset(3, 32'hFFFF_FFFF, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.imem_req && bus.imem_addr == 32'h8) found = 1'b1;
        end
        chk("t3_saw8", 32'(found), 32'h1);
        chk("t3_ack0", 32'(bus.imem_ack), 32'h0);
        tb_redirect = 1'b1; tb_redirect_pc = 32'h100;
        tick();
        tb_redirect = 1'b0;
        chk("t3_flush_req",  bus.imem_req,    32'h1);
        chk("t3_flush_addr", bus.imem_addr,   32'h8);
        chk("t3_flush_val",  bus.instr_valid, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.imem_req && bus.imem_addr == 32'h100) found = 1'b1;
        end
        chk("t3_saw100", 32'(found), 32'h1);
        repeat (8) tick();
        chk("t3_npop", 32'(pop_pc.size() >= 3), 32'h1);
        if (pop_pc.size() >= 3) begin
            chk("t3_pop0", pop_pc[0], 32'h0);
            chk("t3_pop1", pop_pc[1], 32'h4);
            chk("t3_pop2", pop_pc[2], 32'h100);
            chk("t3_ins2", pop_ins[2], 32'h100);
        end
        chk("t3_no8", 32'(count_pc(32'h8)), 32'h0);

        // Redirect coincident with an ack.
        apply_reset(0, 32'hFFFF_FFFF, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.imem_req && bus.imem_addr == 32'h8) found = 1'b1;
        end
        chk("t4_saw8", 32'(found), 32'h1);
        chk("t4_ack1", 32'(bus.imem_ack), 32'h1);
        tb_redirect = 1'b1; tb_redirect_pc = 32'h40;
        tick();
        tb_redirect = 1'b0;
        chk("t4_empty", bus.instr_valid, 32'h0);
        chk("t4_idle",  bus.imem_req,    32'h0);
        tick();
        chk("t4_req",  bus.imem_req,  32'h1);
        chk("t4_addr", bus.imem_addr, 32'h40);
        tick();
        chk("t4_valid", bus.instr_valid, 32'h1);
        chk("t4_pc",    bus.instr_pc,    32'h40);
        chk("t4_instr", bus.instruction, 32'h40);
        chk("t4_no8", 32'(count_pc(32'h8)), 32'h0);

        // PC wrap after redirect to the top word.
        apply_reset(0, 32'hFFFF_FFFF, 1'b1);
        repeat (3) tick();
        tb_redirect = 1'b1; tb_redirect_pc = 32'hFFFF_FFFC;
        tick();
        tb_redirect = 1'b0;
        pop_pc.delete();
        pop_ins.delete();
        repeat (6) tick();
        chk("t5_npop", 32'(pop_pc.size() >= 3), 32'h1);
        if (pop_pc.size() >= 3) begin
            chk("t5_pc0",  pop_pc[0],  32'hFFFF_FFFC);
            chk("t5_pc1",  pop_pc[1],  32'h0);
            chk("t5_pc2",  pop_pc[2],  32'h4);
            chk("t5_ins1", pop_ins[1], 32'h0);
        end

        // Reset asserted mid-request drops imem_req immediately.
        apply_reset(3, 32'hFFFF_FFFF, 1'b1);
        repeat (2) tick();
        chk("t6_req_live", bus.imem_req, 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_req_drop", bus.imem_req,  32'h0);
        chk("t6_addr_rst", bus.imem_addr, 32'h0);

        // Performance counters: 10 fetches, 3 stall cycles.
        apply_reset(0, 32'd10, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (bus.instr_valid) found = 1'b1;
        end
        chk("t7_valid", 32'(found), 32'h1);
        tb_ready = 1'b0;
        repeat (3) tick();
        tb_ready = 1'b1;
        repeat (25) tick();
        chk("t7_nacc", 32'(acc_addr.size()), 32'd10);
        chk("t7_npop", 32'(pop_pc.size()), 32'd10);
        if (pop_pc.size() == 10) chk("t7_last", pop_pc[9], 32'h24);
`ifdef IFU_PERF_CNT_EN
        chk("t7_fetch_cnt", bus.fetch_cnt, 32'd10);
        chk("t7_stall_cnt", bus.stall_cnt, 32'd3);
`else
        chk("t7_fetch_cnt", bus.fetch_cnt, 32'd0);
        chk("t7_stall_cnt", bus.stall_cnt, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
